debounce_scan_sched: RTL and testbench

//  Time-shared debounce scheduler for NUM_CH raw switch/button inputs.
//  One countdown engine visits one channel per scan step, round-robin. Per-channel state, counter and

---
 rtl/debounce_pkg.sv | 17 +
 rtl/debounce_scan_sched_arb.sv | 34 +++
 rtl/debounce_scan_sched.sv | 181 ++++++++++++++++++
 tb/tb_debounce_scan_sched.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the time-shared debounce scheduler.
// Channel state encoding, default reload value, index-width helper.
package debounce_pkg;

  typedef enum logic {
    ST_TRANSFER = 1'b0,
    ST_DELAY    = 1'b1
  } ch_st_e;

  localparam int DEF_DELAY_CNT = 3;

  // $clog2 with a floor of 1 so single-bit indices never collapse
  function automatic int ch_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_scan_sched_arb.sv
// Round-robin grant picker: first pending channel at or after ptr_i.
// Ports: pend_i pending vector, ptr_i rr start, gnt_idx_o/gnt_vld_o grant.
module evt_rr_arbiter
  import debounce_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int IW     = ch_idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] pend_i,
  input  logic [IW-1:0]     ptr_i,
  output logic [IW-1:0]     gnt_idx_o,
  output logic              gnt_vld_o
);

  logic [IW:0] sum;

  // Walk offsets from farthest to nearest so the nearest pending wins.
  always_comb begin
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    sum       = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      sum = {1'b0, ptr_i} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_CH)) begin
        sum = sum - (IW+1)'(NUM_CH);
      end
      if (pend_i[sum[IW-1:0]]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/debounce_scan_sched.sv
// Time-shared debounce engine: one channel per scan step, round-robin.
// Ports: clk_i/rst_i/en_i, raw_sig_i in, debounce_sig_o, evt_* handshake.
module debounce_scan_sched
  import debounce_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 2,
  parameter int DELAY_CNT = DEF_DELAY_CNT,
  parameter int TICK_DIV  = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic [NUM_CH-1:0]           raw_sig_i,
  output logic [NUM_CH-1:0]           debounce_sig_o,
  output logic                        evt_valid_o,
  input  logic                        evt_ready_i,
  output logic [ch_idx_w(NUM_CH)-1:0] evt_ch_o,
  output logic                        evt_rise_o,
  output logic                        evt_ovf_o
);

  localparam int IW = ch_idx_w(NUM_CH);
  localparam int PW = ch_idx_w(TICK_DIV);

  localparam logic [CNT_W-1:0] RELOAD     = CNT_W'(DELAY_CNT);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [IW-1:0]    PTR_LAST   = IW'(NUM_CH - 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  ch_st_e            st_q [NUM_CH];
  ch_st_e            st_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] stable_q, stable_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] dir_q, dir_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic              evt_valid_q, evt_valid_d;
  logic [IW-1:0]     evt_ch_q, evt_ch_d;
  logic              evt_rise_q, evt_rise_d;
  logic              ovf_q, ovf_d;

  logic          step;
  logic          commit;
  logic          load;
  logic          cur_raw;
  logic          cur_stb;
  logic [IW-1:0] gnt_idx;
  logic          gnt_vld;

  evt_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .pend_i    (pend_q),
    .ptr_i     (rr_q),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  always_comb begin
    presc_d = presc_q;
    ptr_d   = ptr_q;
    step    = 1'b0;
    if (en_i) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        step    = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    if (step) begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    commit   = 1'b0;
    cur_raw  = raw_sig_i[ptr_q];
    cur_stb  = stable_q[ptr_q];
    if (step) begin
      unique case (st_q[ptr_q])
        ST_TRANSFER: begin
          if (cur_raw != cur_stb) begin
            st_d[ptr_q]  = ST_DELAY;
            cnt_d[ptr_q] = RELOAD;
          end
        end
        ST_DELAY: begin
          if (cnt_q[ptr_q] != '0) begin
            cnt_d[ptr_q] = cnt_q[ptr_q] - 1'b1;
          end else begin
            st_d[ptr_q]  = ST_TRANSFER;
            cnt_d[ptr_q] = RELOAD;
            // Only the level seen on the final visit decides the commit.
            if (cur_raw != cur_stb) begin
              stable_d[ptr_q] = cur_raw;
              commit          = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    load        = !evt_valid_q || evt_ready_i;
    pend_d      = pend_q;
    dir_d       = dir_q;
    rr_d        = rr_q;
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    evt_rise_d  = evt_rise_q;
    ovf_d       = ovf_q;
    if (load) begin
      if (gnt_vld) begin
        evt_valid_d     = 1'b1;
        evt_ch_d        = gnt_idx;
        evt_rise_d      = dir_q[gnt_idx];
        pend_d[gnt_idx] = 1'b0;
        rr_d = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;
      end else begin
        evt_valid_d = 1'b0;
      end
    end
    // A commit applied after the grant: set wins over clear, and a
    // same-cycle grant already carried the old direction out.
    if (commit) begin
      if (pend_q[ptr_q] && !(load && gnt_vld && (gnt_idx == ptr_q))) begin
        ovf_d = 1'b1;
      end
      pend_d[ptr_q] = 1'b1;
      dir_d[ptr_q]  = cur_raw;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q     <= '0;
      ptr_q       <= '0;
      stable_q    <= '0;
      pend_q      <= '0;
      dir_q       <= '0;
      rr_q        <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_rise_q  <= 1'b0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= ST_TRANSFER;
        cnt_q[i] <= RELOAD;
      end
    end else begin
      presc_q     <= presc_d;
      ptr_q       <= ptr_d;
      stable_q    <= stable_d;
      pend_q      <= pend_d;
      dir_q       <= dir_d;
      rr_q        <= rr_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      evt_rise_q  <= evt_rise_d;
      ovf_q       <= ovf_d;
      st_q        <= st_d;
      cnt_q       <= cnt_d;
    end
  end

  assign debounce_sig_o = stable_q;
  assign evt_valid_o    = evt_valid_q;
  assign evt_ch_o       = evt_ch_q;
  assign evt_rise_o     = evt_rise_q;
  assign evt_ovf_o      = ovf_q;

endmodule

// File: tb/tb_debounce_scan_sched.sv
// Directed bench for debounce_scan_sched (NUM_CH=4, DELAY_CNT=3).
// Edges after reset release are E1, E2, ...; ch k is visited at E(k+1+4n).
module tb_debounce_scan_sched;
  import debounce_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       ready;
  logic [3:0] raw;
  logic [3:0] deb;
  logic       valid;
  logic [1:0] ch;
  logic       rise;
  logic       ovf;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  debounce_scan_sched #(
    .NUM_CH    (4),
    .CNT_W     (2),
    .DELAY_CNT (3),
    .TICK_DIV  (1)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .en_i           (en),
    .raw_sig_i      (raw),
    .debounce_sig_o (deb),
    .evt_valid_o    (valid),
    .evt_ready_i    (ready),
    .evt_ch_o       (ch),
    .evt_rise_o     (rise),
    .evt_ovf_o      (ovf)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [3:0] r);
    rst = 1'b1;
    raw = r;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    ready = 1'b0;
    raw   = 4'hF;

    // T1 reset with all inputs high
    tick(2);
    chk("t1_deb", 32'(deb), 32'h0);
    chk("t1_valid", 32'(valid), 32'h0);
    chk("t1_ch", 32'(ch), 32'h0);
    chk("t1_rise", 32'(rise), 32'h0);
    chk("t1_ovf", 32'(ovf), 32'h0);
    chk("t1_ptr", 32'(dut.ptr_q), 32'h0);
    rst = 1'b0;
    raw = 4'h1;
    tick();
    chk("t1_st0", 32'(dut.st_q[0]), 32'(ST_DELAY));
    chk("t1_cnt0", 32'(dut.cnt_q[0]), 32'h3);
    chk("t1_ptr1", 32'(dut.ptr_q), 32'h1);

    // T2 clean press on ch2: detect E3, commit E19, event E20
    do_reset(4'h0);
    raw = 4'h4;
    tick(18);
    chk("t2_deb_pre", 32'(deb), 32'h0);
    tick();
    chk("t2_deb", 32'(deb), 32'h4);
    chk("t2_valid0", 32'(valid), 32'h0);
    tick();
    chk("t2_valid", 32'(valid), 32'h1);
    chk("t2_ch", 32'(ch), 32'h2);
    chk("t2_rise", 32'(rise), 32'h1);
    ready = 1'b1;
    tick();
    chk("t2_drain", 32'(valid), 32'h0);

    // T3 bounce on ch1: high for one visit only
    ready = 1'b0;
    do_reset(4'h0);
    raw = 4'h2;
    tick(2);
    chk("t3_st_dly", 32'(dut.st_q[1]), 32'(ST_DELAY));
    raw = 4'h0;
    tick(16);
    chk("t3_deb", 32'(deb), 32'h0);
    chk("t3_st", 32'(dut.st_q[1]), 32'(ST_TRANSFER));
    chk("t3_cnt", 32'(dut.cnt_q[1]), 32'h3);
    tick();
    chk("t3_valid", 32'(valid), 32'h0);

    // T4 arbitration: ch0 commits E17, ch3 commits E20
    do_reset(4'h0);
    raw = 4'h9;
    tick(21);
    chk("t4_valid", 32'(valid), 32'h1);
    chk("t4_ch0", 32'(ch), 32'h0);
    chk("t4_rise0", 32'(rise), 32'h1);
    chk("t4_pend", 32'(dut.pend_q), 32'h8);
    chk("t4_rr1", 32'(dut.rr_q), 32'h1);
    chk("t4_deb", 32'(deb), 32'h9);
    ready = 1'b1;
    tick();
    chk("t4_valid3", 32'(valid), 32'h1);
    chk("t4_ch3", 32'(ch), 32'h3);
    chk("t4_rr0", 32'(dut.rr_q), 32'h0);
    tick();
    chk("t4_drain", 32'(valid), 32'h0);

    // T5 overflow: ch0 holds output, ch1 commits rise then fall
    ready = 1'b0;
    do_reset(4'h0);
    raw = 4'h3;
    tick(18);
    raw = 4'h1;
    tick(19);
    chk("t5_hold_ch", 32'(ch), 32'h0);
    chk("t5_ovf_pre", 32'(ovf), 32'h0);
    tick();
    chk("t5_ovf", 32'(ovf), 32'h1);
    chk("t5_deb", 32'(deb), 32'h1);
    ready = 1'b1;
    tick();
    chk("t5_valid", 32'(valid), 32'h1);
    chk("t5_ch", 32'(ch), 32'h1);
    chk("t5_rise", 32'(rise), 32'h0);
    tick();
    chk("t5_drain", 32'(valid), 32'h0);
    chk("t5_ovf_sticky", 32'(ovf), 32'h1);

    // T6 enable freeze, drain while frozen, reset mid-delay
    ready = 1'b0;
    do_reset(4'h0);
    chk("t6_ovf_clr", 32'(ovf), 32'h0);
    raw = 4'h5;
    tick(19);
    chk("t6_hold_ch0", 32'(ch), 32'h0);
    en    = 1'b0;
    ready = 1'b1;
    tick();
    chk("t6_drain_v", 32'(valid), 32'h1);
    chk("t6_drain_ch", 32'(ch), 32'h2);
    chk("t6_drain_r", 32'(rise), 32'h1);
    tick();
    chk("t6_drain_end", 32'(valid), 32'h0);
    chk("t6_ptr_frz", 32'(dut.ptr_q), 32'h3);
    en  = 1'b1;
    raw = 4'h1;
    tick(8);
    chk("t6_cnt2", 32'(dut.cnt_q[2]), 32'h2);
    chk("t6_st2", 32'(dut.st_q[2]), 32'(ST_DELAY));
    en = 1'b0;
    tick(6);
    chk("t6_cnt_frz", 32'(dut.cnt_q[2]), 32'h2);
    chk("t6_ptr_frz2", 32'(dut.ptr_q), 32'h3);
    rst = 1'b1;
    raw = 4'h0;
    en  = 1'b1;
    tick();
    chk("t6_rst_deb", 32'(deb), 32'h0);
    chk("t6_rst_valid", 32'(valid), 32'h0);
    chk("t6_rst_st2", 32'(dut.st_q[2]), 32'(ST_TRANSFER));
    chk("t6_rst_cnt2", 32'(dut.cnt_q[2]), 32'h3);
    chk("t6_rst_ptr", 32'(dut.ptr_q), 32'h0);
    chk("t6_rst_pend", 32'(dut.pend_q), 32'h0);
    rst = 1'b0;
    tick(20);
    chk("t6_no_stale", 32'(valid), 32'h0);
    chk("t6_deb_end", 32'(deb), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
